// File: rtl/sram_axil_ctrl.sv
// AXI4-Lite slave in front of a single-port byte-writable SRAM.
// Optional zero-fill sweep after reset; round-robin write/read arbitration.
module sram_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH          = 1024,
  parameter int INIT_ON_RESET      = 1
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            init_done
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / 8;
  localparam int OFF_W = $clog2(SW);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_MEM  = 3'd3,
    S_RD_RESP = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;

  // Any address bit above the word-index field means the access misses the array.
  function automatic logic addr_oor(input logic [AW-1:0] a);
    return |(a >> (OFF_W + IDX_W));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_init_idx;
  logic               r_init_done;
  logic               r_wr_prio;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_rvalid;
  logic [1:0]         r_rresp;
  logic [DW-1:0]      r_rdata;
  logic [IDX_W-1:0]   r_rd_idx;
  logic               r_rd_oor;
  logic [DW-1:0]      r_mem [MEM_DEPTH];

  logic               w_wr_pend;
  logic               w_rd_pend;
  logic               w_aw_oor;
  logic               w_ar_oor;
  logic               w_wr_grant;
  logic               w_rd_grant;
  logic               w_awready;
  logic               w_wready;
  logic               w_arready;
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_mem_idx;
  logic [DW-1:0]      w_mem_wdata;
  logic [SW-1:0]      w_mem_strb;
  logic               w_unused;

  assign w_wr_pend = s00_axi_awvalid & s00_axi_wvalid;
  assign w_rd_pend = s00_axi_arvalid;
  assign w_aw_oor  = addr_oor(s00_axi_awaddr);
  assign w_ar_oor  = addr_oor(s00_axi_araddr);
  assign w_unused  = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[OFF_W-1:0], s00_axi_araddr[OFF_W-1:0]};

  // Next-state, handshake and memory-port decode.
  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_arready   = 1'b0;
    w_wr_grant  = 1'b0;
    w_rd_grant  = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_idx   = r_init_idx;
    w_mem_wdata = '0;
    w_mem_strb  = '0;
    case (r_state)
      S_INIT: begin
        w_mem_we   = 1'b1;
        w_mem_strb = '1;
        if (r_init_idx == LAST_IDX) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_INIT;
        end
      end
      S_IDLE: begin
        if (r_init_done && w_wr_pend && (!w_rd_pend || r_wr_prio)) begin
          w_wr_grant  = 1'b1;
          w_awready   = 1'b1;
          w_wready    = 1'b1;
          w_mem_we    = ~w_aw_oor;
          w_mem_idx   = addr_idx(s00_axi_awaddr);
          w_mem_wdata = s00_axi_wdata;
          w_mem_strb  = s00_axi_wstrb;
          w_state_nxt = S_WR_RESP;
        end else if (r_init_done && w_rd_pend) begin
          w_rd_grant  = 1'b1;
          w_arready   = 1'b1;
          w_state_nxt = S_RD_MEM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_RESP: begin
        if (s00_axi_bready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WR_RESP;
        end
      end
      S_RD_MEM: begin
        w_state_nxt = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (s00_axi_rready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RD_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, arbitration pointer and response-channel registers.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_state     <= RESET_STATE;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_wr_prio   <= 1'b1;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rresp     <= RESP_OKAY;
      r_rd_idx    <= '0;
      r_rd_oor    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt != S_INIT);
      if (r_state == S_INIT) begin
        r_init_idx <= r_init_idx + IDX_W'(1);
      end
      // The pointer only moves when both sides actually contended.
      if ((w_wr_grant | w_rd_grant) & w_wr_pend & w_rd_pend) begin
        r_wr_prio <= ~r_wr_prio;
      end
      if (w_wr_grant) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_rd_grant) begin
        r_rd_idx <= addr_idx(s00_axi_araddr);
        r_rd_oor <= w_ar_oor;
      end
      if (r_state == S_RD_MEM) begin
        r_rvalid <= 1'b1;
        r_rresp  <= r_rd_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Synchronous read port, loaded only in RD_MEM so rdata holds through RD_RESP.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_rdata <= '0;
    end else if (r_state == S_RD_MEM) begin
      r_rdata <= r_rd_oor ? '0 : r_mem[r_rd_idx];
    end
  end

  // Byte-enabled write port; never written while reset is applied.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_aresetn && w_mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (w_mem_strb[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign s00_axi_awready = w_awready;
  assign s00_axi_wready  = w_wready;
  assign s00_axi_arready = w_arready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rresp   = r_rresp;
  assign s00_axi_rdata   = r_rdata;
  assign init_done       = r_init_done;

endmodule

// File: tb/tb_sram_axil_ctrl.sv
// Self-checking bench for sram_axil_ctrl (32-bit data, 16 words, zero-fill on reset).
module tb_sram_axil_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, init_done;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [16];
  int          n_vec = 0;
  int          n_err = 0;
  int          viol  = 0;

  sram_axil_ctrl #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .MEM_DEPTH(16), .INIT_ON_RESET(1)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bvalid && rvalid) viol++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] ed, logic [1:0] er);
    vec_t v;
    v.is_wr = w; v.addr = a; v.wdata = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
    return v;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < 32'h40) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat, output bit ok);
    ok = 1'b0; lat = 0; resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (bvalid) begin lat = k; ok = 1'b1; break; end
      end
      resp = bresp;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat, output bit ok);
    ok = 1'b0; lat = 0; d = '0; resp = 2'b11;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (rvalid) begin lat = k; ok = 1'b1; break; end
      end
      d = rdata; resp = rresp;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t        e;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          ok;
    sb.push_back('{data: v.exp_data, resp: v.exp_resp});
    d = '0;
    if (v.is_wr) do_write(v.addr, v.wdata, v.strb, r, lat, ok);
    else         do_read(v.addr, d, r, lat, ok);
    e = sb.pop_front();
    check({tag, "_done"}, 64'(ok), 64'd1);
    check({tag, "_resp"}, 64'(r), 64'(e.resp));
    if (v.is_wr) begin
      check({tag, "_blat"}, 64'(lat), 64'd1);
      if (v.exp_resp == 2'b00) mdl_write(v.addr, v.wdata, v.strb);
    end else begin
      check({tag, "_rdata"}, 64'(d), 64'(e.data));
      check({tag, "_rlat"}, 64'(lat), 64'd2);
    end
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (init_done) break;
      if (awready || wready || arready) seen++;
    end
    check({tag, "_init_cycles"}, 64'(cnt), 64'd16);
    check({tag, "_init_ready"}, 64'(seen), 64'd0);
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endtask

  initial begin
    vec_t        vt [22];
    vec_t        v;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          ok;
    int          seen;

    vt[0]  = mk(1'b0, 32'h00, 32'h0,        4'h0, 32'h00000000, 2'b00);
    vt[1]  = mk(1'b1, 32'h00, 32'h1,        4'hF, 32'h0,        2'b00);
    vt[2]  = mk(1'b1, 32'h04, 32'h2,        4'hF, 32'h0,        2'b00);
    vt[3]  = mk(1'b1, 32'h08, 32'h3,        4'hF, 32'h0,        2'b00);
    vt[4]  = mk(1'b1, 32'h0C, 32'h4,        4'hF, 32'h0,        2'b00);
    vt[5]  = mk(1'b0, 32'h00, 32'h0,        4'h0, 32'h00000001, 2'b00);
    vt[6]  = mk(1'b0, 32'h04, 32'h0,        4'h0, 32'h00000002, 2'b00);
    vt[7]  = mk(1'b0, 32'h08, 32'h0,        4'h0, 32'h00000003, 2'b00);
    vt[8]  = mk(1'b0, 32'h0C, 32'h0,        4'h0, 32'h00000004, 2'b00);
    vt[9]  = mk(1'b1, 32'h40, 32'hAABBCCDD, 4'hF, 32'h0,        2'b10);
    vt[10] = mk(1'b0, 32'h00, 32'h0,        4'h0, 32'h00000001, 2'b00);
    vt[11] = mk(1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 32'h0,        2'b00);
    vt[12] = mk(1'b1, 32'h08, 32'h11223344, 4'h5, 32'h0,        2'b00);
    vt[13] = mk(1'b0, 32'h08, 32'h0,        4'h0, 32'hAA22CC44, 2'b00);
    vt[14] = mk(1'b0, 32'h40, 32'h0,        4'h0, 32'h00000000, 2'b10);
    vt[15] = mk(1'b0, 32'h03, 32'h0,        4'h0, 32'h00000001, 2'b00);
    vt[16] = mk(1'b1, 32'h80000004, 32'hFFFFFFFF, 4'hF, 32'h0,  2'b10);
    vt[17] = mk(1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00);
    vt[18] = mk(1'b0, 32'h04, 32'h0,        4'h0, 32'h00000002, 2'b00);
    vt[19] = mk(1'b1, 32'h3C, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00);
    vt[20] = mk(1'b0, 32'h3F, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00);
    vt[21] = mk(1'b0, 32'h80000000, 32'h0,  4'h0, 32'h00000000, 2'b10);

    rstn = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;

    // Reset state with all valids asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_readies", 64'({awready, wready, arready}), 64'd0);
    check("rst_valids", 64'({bvalid, rvalid}), 64'd0);
    check("rst_resps", 64'({bresp, rresp}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rstn = 1'b1;
    wait_init("boot");

    for (int i = 0; i < 22; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Random traffic against the bench's own memory model
    for (int i = 0; i < 24; i++) begin
      v.is_wr = 1'($urandom_range(0, 1));
      v.addr  = 32'($urandom_range(0, 79));
      v.wdata = $urandom;
      v.strb  = 4'($urandom_range(0, 15));
      if (v.addr < 32'h40) begin
        v.exp_resp = 2'b00;
        v.exp_data = v.is_wr ? 32'h0 : mdl[v.addr[5:2]];
      end else begin
        v.exp_resp = 2'b10;
        v.exp_data = 32'h0;
      end
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // bready held low: response held, reads blocked
    awaddr = 32'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("hold_awready", 64'({awready, wready}), 64'h3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; araddr = 32'h0; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_b%0d", i), 64'({bvalid, bresp, arready}), 64'b1000);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    mdl_write(32'h0, 32'h55, 4'hF);
    do_read(32'h0, d, r, lat, ok);
    check("hold_rd", 64'({ok, r, d}), {31'd0, 1'b1, 2'b00, mdl[0]});

    // Lone AW, then lone W: never accepted
    seen = 0;
    awaddr = 32'h4; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (awready || wready) seen++;
    end
    awvalid = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (awready || wready) seen++;
    end
    check("lone_channel_ready", 64'(seen), 64'd0);
    @(posedge clk); #1;
    wvalid = 1'b0;

    // Reset while in RD_MEM: response dropped, INIT restarts
    araddr = 32'h0; arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    check("rdmem_ar_hs", 64'(ok), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rdmem_rst_out", 64'({rvalid, init_done, rdata}), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_init("restart");

    // Write and read contend twice: write first, then read
    awaddr = 32'h4; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h4; arvalid = 1'b1;
    @(negedge clk);
    check("arb1_grant", 64'({awready, wready, arready}), 64'b110);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("arb1_b", 64'({bvalid, bresp, arready}), 64'b1000);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    mdl_write(32'h4, 32'h77, 4'hF);
    awaddr = 32'h8; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("arb2_grant", 64'({awready, wready, arready}), 64'b001);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("arb2_rdmem", 64'({rvalid, awready}), 64'd0);
    @(negedge clk);
    check("arb2_r", 64'({rvalid, rresp, awready, rdata}), {29'd0, 1'b1, 2'b00, 1'b0, 32'h77});
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    do_write(32'h8, 32'h99, 4'hF, r, lat, ok);
    check("arb3_wr", 64'({ok, r, 32'(lat)}), {29'd0, 1'b1, 2'b00, 32'd1});
    mdl_write(32'h8, 32'h99, 4'hF);

    run_vec(mk(1'b0, 32'h00, 32'h0, 4'h0, 32'h00000000, 2'b00), "post_rst_w0");
    run_vec(mk(1'b0, 32'h08, 32'h0, 4'h0, 32'h00000099, 2'b00), "post_rst_w2");
    run_vec(mk(1'b0, 32'h3C, 32'h0, 4'h0, 32'h00000000, 2'b00), "post_rst_w15");

    check("b_r_exclusive", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
